// File: rtl/sensor_irq_arbiter_pkg.sv
// Shared types and helpers for the sensor interrupt arbiter and other NI arbiters.
// Holds the FSM state encoding, default sizing and the one-hot decoder.
package sensor_irq_arbiter_pkg;

    localparam int N_SENSOR_DEF = 4;
    localparam int ID_W_DEF     = 2;
    localparam int TIMEOUT_DEF  = 64;
    localparam int CNT_W_DEF    = 7;

    // Widest sensor bank supported by onehot_dec; callers truncate to their width.
    localparam int MAX_SENSOR   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_CLR  = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_e;

    function automatic logic [MAX_SENSOR-1:0] onehot_dec(input int idx);
        logic [MAX_SENSOR-1:0] vec;
        vec = MAX_SENSOR'(1) << idx;
        return vec;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set bit of pend at or after last_grant+1, with wrap.
// Uses a double-width copy of pend shifted by the start index, then a low-first priority encode.
module rr_priority_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    pend,
    input  logic [ID_W-1:0] last_grant,
    output logic [ID_W-1:0] winner,
    output logic            any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             start;
    int             off;

    always_comb begin
        start = (int'(last_grant) + 1) % N;
        dbl   = {pend, pend};
        rot   = N'(dbl >> start);
        off   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = i;
        end
        winner = ID_W'((start + off) % N);
        any    = |pend;
    end

endmodule

// File: rtl/sensor_irq_arbiter.sv
// Shares one NI injection port among sticky sensor interrupts, round-robin, with ack timeout.
// All outputs are registered and decoded from the next state.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | arbitrate unmasked pending irqs, latch winner
//  REQ   | pkt_req high for grant_id, wait for pkt_ack or timeout
//  CLR   | one-cycle irq_clr pulse to the granted sensor
//  GAP   | let the sensor drop its irq before re-arbitrating
module sensor_irq_arbiter
    import sensor_irq_arbiter_pkg::*;
#(
    parameter int N_SENSOR = N_SENSOR_DEF,
    parameter int ID_W     = ID_W_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_SENSOR-1:0] irq,
    input  logic [N_SENSOR-1:0] irq_mask,
    output logic                pkt_req,
    output logic [ID_W-1:0]     pkt_id,
    input  logic                pkt_ack,
    output logic [N_SENSOR-1:0] irq_clr,
    output logic                busy,
    output logic                timeout_err
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  LAST_RESET = ID_W'(N_SENSOR - 1);

    arb_state_e          state, state_nxt;
    logic [ID_W-1:0]     grant_id, grant_id_nxt;
    logic [ID_W-1:0]     last_grant, last_grant_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [N_SENSOR-1:0] pend;
    logic [N_SENSOR-1:0] clr_nxt;
    logic [ID_W-1:0]     winner;
    logic                any;
    logic                timeout_hit;

    assign pend = irq & ~irq_mask;

    rr_priority_pick #(
        .N    (N_SENSOR),
        .ID_W (ID_W)
    ) u_pick (
        .pend       (pend),
        .last_grant (last_grant),
        .winner     (winner),
        .any        (any)
    );

    always_comb begin
        state_nxt      = state;
        grant_id_nxt   = grant_id;
        last_grant_nxt = last_grant;
        cnt_nxt        = cnt;
        timeout_hit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any) begin
                    grant_id_nxt = winner;
                    cnt_nxt      = '0;
                    state_nxt    = ST_REQ;
                end
            end
            ST_REQ: begin
                // Ack takes precedence over a timeout landing on the same cycle.
                if (pkt_ack) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_CLR;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = ST_CLR;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_CLR: begin
                last_grant_nxt = grant_id;
                state_nxt      = ST_GAP;
            end
            ST_GAP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        clr_nxt = '0;
        if (state_nxt == ST_CLR) clr_nxt = N_SENSOR'(onehot_dec(int'(grant_id_nxt)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            grant_id    <= '0;
            last_grant  <= LAST_RESET;
            cnt         <= '0;
            pkt_req     <= 1'b0;
            pkt_id      <= '0;
            irq_clr     <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant_id    <= grant_id_nxt;
            last_grant  <= last_grant_nxt;
            cnt         <= cnt_nxt;
            pkt_req     <= (state_nxt == ST_REQ);
            pkt_id      <= grant_id_nxt;
            irq_clr     <= clr_nxt;
            busy        <= (state_nxt != ST_IDLE);
            timeout_err <= timeout_err | timeout_hit;
        end
    end

endmodule
